// File: rtl/stencil_scanout.sv
// Purpose : scans a 2^X x 2^Y stencil buffer in raster order and streams it out as pixels.
// Latency : start sampled at edge c -> first rd_en in cycle c+1, first pix_valid in c+3.
// Backpr. : pix_ready low stops issue once 2 reads are in flight or buffered; head holds steady.
//
// Ports:
//   clock, resetn      sole clock, synchronous active-low reset
//   start              frame request, only honoured in IDLE
//   rd_address/rd_en   buffer read request ({y,x}); rd_data returns one cycle later
//   pix_*              valid/ready pixel stream with coordinates and end-of-frame flag
//   busy, done         frame in progress / one-cycle completion pulse
module stencil_scanout #(
    parameter int DATA_WIDTH = 12,
    parameter int X_WIDTH    = 5,
    parameter int Y_WIDTH    = 5,
    parameter int ADDR_WIDTH = X_WIDTH + Y_WIDTH
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] rd_address,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] pix_data,
    output logic [X_WIDTH-1:0]    pix_x,
    output logic [Y_WIDTH-1:0]    pix_y,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  pix_last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Issue counter: address of the next read to issue.
    logic [X_WIDTH-1:0] x_cnt;
    logic [Y_WIDTH-1:0] y_cnt;
    logic               last_addr;

    // Read issued last cycle; its data is on rd_data this cycle.
    logic               inflight;
    logic [X_WIDTH-1:0] inflight_x;
    logic [Y_WIDTH-1:0] inflight_y;

    // Two-entry in-order pixel FIFO.
    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic [X_WIDTH-1:0]    fifo_x    [2];
    logic [Y_WIDTH-1:0]    fifo_y    [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;

    logic       push;
    logic       pop;
    logic [2:0] occupancy;
    logic       room;

    assign last_addr  = (&x_cnt) & (&y_cnt);
    assign rd_address = ADDR_WIDTH'({y_cnt, x_cnt});

    assign push      = inflight;
    assign pix_valid = (count != 2'd0);
    assign pop       = pix_valid & pix_ready;
    assign pix_data  = fifo_data[rd_ptr];
    assign pix_x     = fifo_x[rd_ptr];
    assign pix_y     = fifo_y[rd_ptr];
    assign pix_last  = pix_valid & (&pix_x) & (&pix_y);

    // Everything already committed (buffered or returning) minus what leaves
    // this cycle must leave a slot free, so a push never meets a full FIFO
    // without a matching pop. pop implies count >= 1, so no underflow.
    assign occupancy = {1'b0, count} + {2'b00, inflight};
    assign room      = (occupancy - {2'b00, pop}) < 3'd2;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (rd_en && last_addr) state_nxt = S_DRAIN;
            S_DRAIN: if (pop && pix_last) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        rd_en = 1'b0;
        busy  = 1'b0;
        case (state)
            S_RUN: begin
                rd_en = room;
                busy  = 1'b1;
            end
            S_DRAIN: busy = 1'b1;
            default: begin
                rd_en = 1'b0;
                busy  = 1'b0;
            end
        endcase
    end

    // Issue counter. Holds at the final address after the last issue so the
    // address bus stays quiet until the next frame clears it.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (state == S_IDLE && start) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (rd_en && !last_addr) begin
            x_cnt <= x_cnt + 1'b1;
            if (&x_cnt) begin
                y_cnt <= y_cnt + 1'b1;
            end
        end
    end

    // Tag the returning read with the coordinates it was issued for.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            inflight   <= 1'b0;
            inflight_x <= '0;
            inflight_y <= '0;
        end else begin
            inflight   <= rd_en;
            inflight_x <= x_cnt;
            inflight_y <= y_cnt;
        end
    end

    // Pixel FIFO; storage is cleared on reset so the head reads as zero.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_x[i]    <= '0;
                fifo_y[i]    <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= rd_data;
                fifo_x[wr_ptr]    <= inflight_x;
                fifo_y[wr_ptr]    <= inflight_y;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Completion pulse lands in the cycle after the final transfer, when the
    // FSM is already back in IDLE.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            done <= 1'b0;
        end else begin
            done <= pop & pix_last;
        end
    end

endmodule

// File: tb/tb_stencil_scanout.sv
module tb_stencil_scanout;

    localparam int DW = 12;
    localparam int XW = 2;
    localparam int YW = 2;
    localparam int AW = XW + YW;

    logic          clock;
    logic          resetn;
    logic          start;
    logic [AW-1:0] rd_address;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] pix_data;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic          pix_valid;
    logic          pix_ready;
    logic          pix_last;
    logic          busy;
    logic          done;

    int total;
    int bad;

    stencil_scanout #(
        .DATA_WIDTH(DW),
        .X_WIDTH   (XW),
        .Y_WIDTH   (YW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .rd_address(rd_address),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .pix_data  (pix_data),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_last  (pix_last),
        .busy      (busy),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Buffer model: mem[i] = 3*i, registered read.
    always @(posedge clock) rd_data <= DW'(32'(rd_address) * 3);

    task automatic test_reset();
        logic [31:0] outs;
        resetn    = 1'b0;
        start     = 1'b1;
        pix_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clock); #1;
            outs = 32'({rd_address, rd_en, pix_data, pix_x, pix_y, pix_valid, pix_last, busy, done});
            total++;
            if (outs !== 32'd0) begin
                bad++;
                $display("FAIL reset_outputs cycle=%0d got=%0h exp=0", c, outs);
            end
        end
        resetn = 1'b1;
        start  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clock); #1;
            outs = 32'({rd_address, rd_en, pix_data, pix_x, pix_y, pix_valid, pix_last, busy, done});
            total++;
            if (outs !== 32'd0) begin
                bad++;
                $display("FAIL post_reset_idle cycle=%0d got=%0h exp=0", c, outs);
            end
        end
    endtask

    // Full frame with pix_ready high; optional start re-pulse in cycle mid_start.
    // Cycle k counts edges after the start edge.
    task automatic test_frame(input int mid_start);
        int idx;
        pix_ready = 1'b1;
        start     = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            @(posedge clock); #1;
            start = (k == mid_start);
            #1;
            total++;
            if (rd_en !== (k <= 16)) begin
                bad++;
                $display("FAIL frame_rd_en k=%0d got=%0b exp=%0b", k, rd_en, (k <= 16));
            end
            total++;
            if (rd_address !== AW'((k <= 16) ? k - 1 : 15)) begin
                bad++;
                $display("FAIL frame_rd_address k=%0d got=%0d exp=%0d", k, rd_address, (k <= 16) ? k - 1 : 15);
            end
            total++;
            if (pix_valid !== (k >= 3 && k <= 18)) begin
                bad++;
                $display("FAIL frame_pix_valid k=%0d got=%0b exp=%0b", k, pix_valid, (k >= 3 && k <= 18));
            end
            if (k >= 3 && k <= 18) begin
                idx = k - 3;
                total++;
                if (pix_data !== DW'(3 * idx) || pix_x !== XW'(idx % 4) || pix_y !== YW'(idx / 4)) begin
                    bad++;
                    $display("FAIL frame_pixel k=%0d got=%0d(%0d,%0d) exp=%0d(%0d,%0d)",
                             k, pix_data, pix_x, pix_y, 3 * idx, idx % 4, idx / 4);
                end
                total++;
                if (pix_last !== (idx == 15)) begin
                    bad++;
                    $display("FAIL frame_pix_last k=%0d got=%0b exp=%0b", k, pix_last, (idx == 15));
                end
            end
            total++;
            if (busy !== (k <= 18)) begin
                bad++;
                $display("FAIL frame_busy k=%0d got=%0b exp=%0b", k, busy, (k <= 18));
            end
            total++;
            if (done !== (k == 19)) begin
                bad++;
                $display("FAIL frame_done k=%0d got=%0b exp=%0b", k, done, (k == 19));
            end
        end
        start = 1'b0;
    endtask

    // Scoreboard run: mode 0 = 5-cycle stall at head index 4, mode 1 = ready toggles.
    task automatic test_pattern(input int mode);
        int n, issued, stall, done_cnt, last_cyc;
        logic hold;
        logic [DW-1:0] prev_data;
        logic done_seen;
        n = 0; issued = 0; stall = 0; done_cnt = 0; last_cyc = -10;
        hold = 1'b0; prev_data = '0; done_seen = 1'b0;
        start = 1'b1;
        for (int cyc = 1; cyc <= 120 && !done_seen; cyc++) begin
            @(posedge clock); #1;
            start = 1'b0;
            if (mode == 1) begin
                pix_ready = cyc[0];
            end else if (n == 4 && stall < 5) begin
                pix_ready = 1'b0;
                stall++;
            end else begin
                pix_ready = 1'b1;
            end
            #1;
            total++;
            if (issued - n > 2) begin
                bad++;
                $display("FAIL outstanding cyc=%0d got=%0d exp<=2", cyc, issued - n);
            end
            if (rd_en) begin
                total++;
                if (rd_address !== AW'(issued)) begin
                    bad++;
                    $display("FAIL issue_order cyc=%0d got=%0d exp=%0d", cyc, rd_address, issued);
                end
                issued++;
            end
            if (hold) begin
                total++;
                if (pix_valid !== 1'b1 || pix_data !== prev_data) begin
                    bad++;
                    $display("FAIL head_stable cyc=%0d got=%0d exp=%0d", cyc, pix_data, prev_data);
                end
            end
            if (mode == 0 && pix_ready == 1'b0) begin
                total++;
                if (pix_data !== DW'(12) || pix_x !== XW'(0) || pix_y !== YW'(1)) begin
                    bad++;
                    $display("FAIL stall_head cyc=%0d got=%0d(%0d,%0d) exp=12(0,1)", cyc, pix_data, pix_x, pix_y);
                end
            end
            if (mode == 0 && stall == 5 && n >= 5 && n < 16) begin
                total++;
                if (pix_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL resume_gap cyc=%0d got=%0b exp=1", cyc, pix_valid);
                end
            end
            if (pix_valid) begin
                total++;
                if (pix_data !== DW'(3 * n) || pix_x !== XW'(n % 4) || pix_y !== YW'(n / 4) ||
                    pix_last !== (n == 15)) begin
                    bad++;
                    $display("FAIL stream_pixel cyc=%0d got=%0d(%0d,%0d,last=%0b) exp=%0d(%0d,%0d,last=%0b)",
                             cyc, pix_data, pix_x, pix_y, pix_last, 3 * n, n % 4, n / 4, (n == 15));
                end
            end
            if (done) begin
                done_cnt++;
                done_seen = 1'b1;
                total++;
                if (last_cyc != cyc - 1) begin
                    bad++;
                    $display("FAIL done_timing cyc=%0d got_last_xfer=%0d exp=%0d", cyc, last_cyc, cyc - 1);
                end
            end
            hold      = pix_valid & ~pix_ready;
            prev_data = pix_data;
            if (pix_valid && pix_ready) begin
                n++;
                if (n == 16) last_cyc = cyc;
            end
        end
        total++;
        if (!done_seen) begin
            bad++;
            $display("FAIL pattern_timeout mode=%0d got=no_done exp=done", mode);
        end
        pix_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clock); #1;
            if (done) done_cnt++;
        end
        total++;
        if (n != 16 || done_cnt != 1) begin
            bad++;
            $display("FAIL pattern_counts mode=%0d got=xfers %0d done %0d exp=xfers 16 done 1", mode, n, done_cnt);
        end
        if (mode == 0) begin
            total++;
            if (stall != 5) begin
                bad++;
                $display("FAIL stall_cycles got=%0d exp=5", stall);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] outs;
        pix_ready = 1'b1;
        start     = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clock); #1;
            start = 1'b0;
        end
        #1;
        total++;
        if (pix_data !== DW'(21) || pix_valid !== 1'b1) begin
            bad++;
            $display("FAIL midreset_beat7 got=%0d/%0b exp=21/1", pix_data, pix_valid);
        end
        resetn = 1'b0;
        @(posedge clock); #1;
        resetn = 1'b1;
        outs = 32'({rd_address, rd_en, pix_data, pix_x, pix_y, pix_valid, pix_last, busy, done});
        total++;
        if (outs !== 32'd0) begin
            bad++;
            $display("FAIL midreset_outputs got=%0h exp=0", outs);
        end
        @(posedge clock); #1;
        test_frame(0);
    endtask

    task automatic test_back_to_back();
        logic done_seen;
        test_frame(0);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        total++;
        if (rd_en !== 1'b1 || rd_address !== AW'(0) || busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_restart got=rd_en %0b addr %0d busy %0b exp=1 0 1", rd_en, rd_address, busy);
        end
        done_seen = 1'b0;
        for (int c = 0; c < 40 && !done_seen; c++) begin
            @(posedge clock); #1;
            if (done) done_seen = 1'b1;
        end
        total++;
        if (!done_seen) begin
            bad++;
            $display("FAIL b2b_timeout got=no_done exp=done");
        end
        @(posedge clock); #1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        resetn    = 1'b0;
        start     = 1'b0;
        pix_ready = 1'b0;
        test_reset();
        test_frame(0);
        @(posedge clock); #1;
        test_pattern(0);
        test_pattern(1);
        test_frame(6);
        @(posedge clock); #1;
        test_reset_mid();
        @(posedge clock); #1;
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
